// File: rtl/riscv_cache_pkg.sv
// Shared types and line geometry for the data-cache backing-memory refill path.
package riscv_cache_pkg;

  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    BEAT = 2'd2,
    RESP = 2'd3
  } refill_state_e;

  typedef logic [32*LINE_WORDS-1:0] line_data_t;

endpackage

// File: rtl/mem_word_array.sv
// Single-port synchronous word RAM; contents survive reset.
module mem_word_array #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk_i) begin
    if (we_i) r_mem[addr_i] <= wdata_i;
    if (re_i) r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/line_refill_unit.sv
// Serialises cache line fill / write-back requests into word beats on a
// fixed-latency backing memory and returns one completion pulse per request.
module line_refill_unit
  import riscv_cache_pkg::*;
#(
  parameter int LINE_WORDS = 4,
  parameter int MEM_WORDS  = 4096,
  parameter int LAT        = 2
) (
  input  logic                                              clk_i,
  input  logic                                              rst_i,
  input  logic                                              req_valid_i,
  output logic                                              req_ready_o,
  input  logic                                              req_we_i,
  input  logic [$clog2(MEM_WORDS)-$clog2(LINE_WORDS)-1:0]   req_line_i,
  input  logic [32*LINE_WORDS-1:0]                          req_wdata_i,
  output logic                                              resp_valid_o,
  output logic [32*LINE_WORDS-1:0]                          resp_rdata_o,
  output logic                                              busy_o,
  output logic [31:0]                                       no_rd_o,
  output logic [31:0]                                       no_wr_o,
  output refill_state_e                                     dbg_state_o
);

  localparam int ADDR_W = $clog2(MEM_WORDS);
  localparam int OFF_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = ADDR_W - OFF_W;
  localparam int CNT_W  = (LAT > 0) ? $clog2(LAT + 1) : 1;
  localparam int DW     = 32 * LINE_WORDS;

  // Handshake: a request is taken on any edge where req_valid_i and
  // req_ready_o are both high; ready drops for the whole transaction and
  // the response is a single unacknowledged pulse.

  refill_state_e     r_state;
  logic              r_we;
  logic [LINE_W-1:0] r_line;
  logic [DW-1:0]     r_wdata;
  logic [OFF_W-1:0]  r_k;
  logic [CNT_W-1:0]  r_wait;
  logic [DW-33:0]    r_buf;
  logic              r_cap;
  logic [OFF_W-1:0]  r_cap_k;
  logic              r_ready;
  logic              r_busy;
  logic              r_resp_valid;
  logic [31:0]       r_no_rd;
  logic [31:0]       r_no_wr;

  logic [ADDR_W-1:0] w_addr;
  logic              w_mem_we;
  logic              w_mem_re;
  logic [31:0]       w_wword;
  logic [31:0]       w_rword;
  logic              w_last_k;

  assign w_addr   = {r_line, r_k};
  assign w_mem_we = (r_state == BEAT) && r_we;
  assign w_mem_re = (r_state == BEAT) && !r_we;
  assign w_wword  = r_wdata[32*r_k +: 32];
  assign w_last_k = (r_k == OFF_W'(LINE_WORDS - 1));

  mem_word_array #(
    .DEPTH (MEM_WORDS),
    .AW    (ADDR_W)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_mem_we),
    .re_i    (w_mem_re),
    .addr_i  (w_addr),
    .wdata_i (w_wword),
    .rdata_o (w_rword)
  );

  // The RAM output register holds each read word for one cycle; words below
  // the last are copied into r_buf, the last is presented straight from RAM.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_ready      <= 1'b1;
      r_busy       <= 1'b0;
      r_resp_valid <= 1'b0;
      r_no_rd      <= '0;
      r_no_wr      <= '0;
      r_cap        <= 1'b0;
      r_k          <= '0;
      r_wait       <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      r_cap        <= 1'b0;
      if (r_cap) r_buf[32*r_cap_k +: 32] <= w_rword;
      case (r_state)
        IDLE: begin
          if (req_valid_i) begin
            r_we    <= req_we_i;
            r_line  <= req_line_i;
            r_wdata <= req_wdata_i;
            r_k     <= '0;
            r_wait  <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (req_we_i) r_no_wr <= r_no_wr + 32'd1;
            else          r_no_rd <= r_no_rd + 32'd1;
            r_state <= (LAT > 0) ? WAIT : BEAT;
          end
        end
        WAIT: begin
          if (r_wait == CNT_W'(LAT - 1)) begin
            r_wait  <= '0;
            r_state <= BEAT;
          end else begin
            r_wait <= r_wait + 1'b1;
          end
        end
        BEAT: begin
          if (!r_we && !w_last_k) begin
            r_cap   <= 1'b1;
            r_cap_k <= r_k;
          end
          if (w_last_k) begin
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end else begin
            r_k     <= r_k + 1'b1;
            r_state <= (LAT > 0) ? WAIT : BEAT;
          end
        end
        RESP: begin
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = r_ready & ~rst_i;
  assign busy_o       = r_busy;
  assign resp_valid_o = r_resp_valid;
  assign resp_rdata_o = (r_resp_valid && !r_we) ? {w_rword, r_buf} : '0;
  assign no_rd_o      = r_no_rd;
  assign no_wr_o      = r_no_wr;
  assign dbg_state_o  = r_state;

endmodule

// File: tb/tb_line_refill_unit.sv
// Directed bench for line_refill_unit: a LAT=2 instance and a LAT=0 instance.
module tb_line_refill_unit;
  import riscv_cache_pkg::*;

  localparam int LINE_W = 10;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              valid_a = 1'b0;
  logic              valid_b = 1'b0;
  logic              req_we = 1'b0;
  logic [LINE_W-1:0] req_line = '0;
  line_data_t        req_wdata = '0;

  logic              ready_a, resp_a, busy_a;
  logic              ready_b, resp_b, busy_b;
  line_data_t        rdata_a, rdata_b;
  logic [31:0]       no_rd_a, no_wr_a, no_rd_b, no_wr_b;
  refill_state_e     st_a, st_b;

  bit                sel_b = 1'b0;
  logic              obs_ready, obs_resp;
  line_data_t        obs_rdata;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  always #5 clk = ~clk;

  line_refill_unit #(.LINE_WORDS(4), .MEM_WORDS(4096), .LAT(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_a), .req_ready_o(ready_a),
    .req_we_i(req_we), .req_line_i(req_line), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_a), .resp_rdata_o(rdata_a), .busy_o(busy_a),
    .no_rd_o(no_rd_a), .no_wr_o(no_wr_a), .dbg_state_o(st_a)
  );

  line_refill_unit #(.LINE_WORDS(4), .MEM_WORDS(4096), .LAT(0)) u_dut_lat0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(valid_b), .req_ready_o(ready_b),
    .req_we_i(req_we), .req_line_i(req_line), .req_wdata_i(req_wdata),
    .resp_valid_o(resp_b), .resp_rdata_o(rdata_b), .busy_o(busy_b),
    .no_rd_o(no_rd_b), .no_wr_o(no_wr_b), .dbg_state_o(st_b)
  );

  assign obs_ready = sel_b ? ready_b : ready_a;
  assign obs_resp  = sel_b ? resp_b  : resp_a;
  assign obs_rdata = sel_b ? rdata_b : rdata_a;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    assert_cnt++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    repeat (n) tick();
    check_eq("ready_in_rst", {127'd0, ready_a}, 128'd0);
    rst = 1'b0;
    tick();
  endtask

  // Issues one request on the selected instance and returns the cycle
  // (counted from the accept edge) of the response pulse and its data.
  task automatic do_req(input bit sel, input logic we, input logic [LINE_W-1:0] line,
                        input line_data_t wd, output int lat, output line_data_t rd);
    int n = 0;
    sel_b = sel;
    #0;
    while (!obs_ready && n < 50) begin
      tick();
      n++;
    end
    check_eq("ready_wait", {127'd0, obs_ready}, 128'd1);
    req_we = we;
    req_line = line;
    req_wdata = wd;
    if (sel) valid_b = 1'b1;
    else     valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    lat = 1;
    while (!obs_resp && lat < 100) begin
      tick();
      lat++;
    end
    rd = obs_rdata;
    tick();
    check_eq("pulse_single", {127'd0, obs_resp}, 128'd0);
  endtask

  initial begin
    int         lat;
    line_data_t rd;
    int         first, second, zeros, pulses;

    // Reset state
    do_reset(3);
    check_eq("rst_ready",  {127'd0, ready_a}, 128'd1);
    check_eq("rst_busy",   {127'd0, busy_a}, 128'd0);
    check_eq("rst_resp",   {127'd0, resp_a}, 128'd0);
    check_eq("rst_rdata",  rdata_a, 128'd0);
    check_eq("rst_no_rd",  {96'd0, no_rd_a}, 128'd0);
    check_eq("rst_no_wr",  {96'd0, no_wr_a}, 128'd0);
    check_eq("rst_state",  {126'd0, st_a}, {126'd0, IDLE});

    // Preload line 0x10 through a write-back, then fill it
    do_req(1'b0, 1'b1, 10'h010, {32'h44, 32'h33, 32'h22, 32'h11}, lat, rd);
    check_eq("wb10_lat", lat, 13);
    check_eq("wb10_rdata", rd, 128'd0);
    do_reset(1);
    do_req(1'b0, 1'b0, 10'h010, '0, lat, rd);
    check_eq("fill10_lat", lat, 13);
    check_eq("fill10_data", rd, {32'h44, 32'h33, 32'h22, 32'h11});
    check_eq("fill10_no_rd", {96'd0, no_rd_a}, 128'd1);
    check_eq("fill10_no_wr", {96'd0, no_wr_a}, 128'd0);

    // Top line of memory: write-back then fill
    do_reset(1);
    do_req(1'b0, 1'b1, 10'h3FF, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, lat, rd);
    check_eq("wb3ff_lat", lat, 13);
    check_eq("wb3ff_no_wr", {96'd0, no_wr_a}, 128'd1);
    do_req(1'b0, 1'b0, 10'h3FF, '0, lat, rd);
    check_eq("fill3ff_lat", lat, 13);
    check_eq("fill3ff_data", rd, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check_eq("fill3ff_no_rd", {96'd0, no_rd_a}, 128'd1);

    // Request held valid continuously: accepts spaced 14 edges apart
    do_reset(1);
    req_we = 1'b0;
    req_line = 10'h010;
    valid_a = 1'b1;
    first = -1;
    second = -1;
    zeros = 0;
    for (int i = 0; i < 15; i++) begin
      if (ready_a) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end else begin
        zeros++;
      end
      if (i == 13) check_eq("b2b_no_rd_mid", {96'd0, no_rd_a}, 128'd1);
      tick();
    end
    valid_a = 1'b0;
    check_eq("b2b_spacing", second - first, 14);
    check_eq("b2b_ready_low", zeros, 13);
    check_eq("b2b_no_rd", {96'd0, no_rd_a}, 128'd2);
    check_eq("b2b_no_wr", {96'd0, no_wr_a}, 128'd0);

    // Reset in the middle of a write-back to line 0x20
    do_reset(1);
    do_req(1'b0, 1'b1, 10'h020, {32'h5003, 32'h5002, 32'h5001, 32'h5000}, lat, rd);
    do_reset(1);
    req_we = 1'b1;
    req_line = 10'h020;
    req_wdata = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
    valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    check_eq("abort_resp", {127'd0, resp_a}, 128'd0);
    check_eq("abort_busy", {127'd0, busy_a}, 128'd0);
    check_eq("abort_no_wr", {96'd0, no_wr_a}, 128'd0);
    check_eq("abort_ready_in_rst", {127'd0, ready_a}, 128'd0);
    rst = 1'b0;
    tick();
    check_eq("abort_ready_after", {127'd0, ready_a}, 128'd1);
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      if (resp_a) pulses++;
      tick();
    end
    check_eq("abort_no_pulse", pulses, 0);
    do_req(1'b0, 1'b0, 10'h020, '0, lat, rd);
    check_eq("abort_mem", rd, {32'h5003, 32'h5002, 32'hB1, 32'hB0});

    // Reset and request in the same cycle: reset wins
    do_reset(1);
    rst = 1'b1;
    req_we = 1'b0;
    valid_a = 1'b1;
    tick();
    rst = 1'b0;
    valid_a = 1'b0;
    check_eq("rstreq_busy", {127'd0, busy_a}, 128'd0);
    check_eq("rstreq_no_rd", {96'd0, no_rd_a}, 128'd0);
    tick();
    check_eq("rstreq_busy_later", {127'd0, busy_a}, 128'd0);
    check_eq("rstreq_ready", {127'd0, ready_a}, 128'd1);

    // LAT=0 instance, line 0
    do_req(1'b1, 1'b1, 10'h000, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, lat, rd);
    check_eq("lat0_wb_lat", lat, 5);
    do_req(1'b1, 1'b0, 10'h000, '0, lat, rd);
    check_eq("lat0_fill_lat", lat, 5);
    check_eq("lat0_fill_data", rd, {32'hC3, 32'hC2, 32'hC1, 32'hC0});
    check_eq("lat0_no_rd", {96'd0, no_rd_b}, 128'd1);
    check_eq("lat0_no_wr", {96'd0, no_wr_b}, 128'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
